reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised two-read/one-write register file for the filter processor datapath; next generation of the 16x32 register memory.
- Adds generic width and depth, an optional hard-wired zero register, same-cycle write-to-read bypass, per-port read-valid flags, and a hardware clear sequencer that zeroes the whole array after reset or on request.
- Sits between the decode stage (addresses and enables) and the ALU/filter operand inputs.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- IDLE_VAL, {DATA_W{1'b1}}, value driven on a read port when it is disabled or the block is clearing.
- ZERO_REG, 0, when 1, entry 0 always reads 0 and writes to entry 0 are discarded.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr_n  in  1  synchronous active-low clear request; sampled only in RUN.
- dir_a  in  ADDR_W  read address, port A.
- dir_b  in  ADDR_W  read address, port B.
- re_a_n  in  1  active-low read enable, port A.
- re_b_n  in  1  active-low read enable, port B.
- dir_wr  in  ADDR_W  write address.
- di  in  DATA_W  write data.
- we_n  in  1  active-low write enable.
- dat_a  out  DATA_W  registered read data, port A.
- dat_b  out  DATA_W  registered read data, port B.
- valid_a  out  1  dat_a holds array data (not IDLE_VAL).
- valid_b  out  1  dat_b holds array data.
- ready  out  1  high in RUN; low while clearing.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset (rst_n low, asynchronous):
  - state=CLEAR, clr_ptr=0, ready=0, valid_a=valid_b=0, dat_a=dat_b=IDLE_VAL.
  - Array contents are not touched by reset itself.
- CLEAR state:
  - Each rising edge writes 0 to mem[clr_ptr], then clr_ptr increments.
  - The edge that writes entry DEPTH-1 moves the state to RUN and registers ready=1.
  - Result: ready rises on the DEPTH-th rising edge after rst_n deasserts (16 edges with default parameters).
  - we_n, re_a_n, re_b_n and clr_n are ignored.
  - dat_a and dat_b hold IDLE_VAL; valid_a and valid_b hold 0.
- RUN, write: if we_n=0, mem[dir_wr] <= di on the rising edge. If ZERO_REG=1 and dir_wr=0, the write is dropped.
- RUN, read, per port X in {a, b}; latency 1 cycle:
  - If re_X_n=0: dat_X <= rd_X and valid_X <= 1.
  - rd_X = 0 when ZERO_REG=1 and dir_X=0.
  - Otherwise rd_X = di when we_n=0 and dir_wr=dir_X (bypass: the new data is returned).
  - Otherwise rd_X = mem[dir_X].
  - If re_X_n=1: dat_X <= IDLE_VAL and valid_X <= 0.
  - Ports A and B are independent; A and B may read the same address.
- RUN, clr_n=0 at a rising edge:
  - Next state is CLEAR, clr_ptr <= 0, ready <= 0.
  - Any write in the same cycle is dropped; clear wins.
  - Reads in that cycle still complete normally; outputs go to IDLE_VAL/0 from the following edge.
- Address wrap: clr_ptr is ADDR_W bits wide and wraps to 0 on the transition to RUN. Addresses are always in range because DEPTH = 2**ADDR_W.
- Reset mid-CLEAR or mid-RUN: outputs take reset values immediately and the clear sequence restarts from entry 0.
- Width rules: IDLE_VAL and di are exactly DATA_W bits; there is no truncation or extension anywhere.

Test Plan:
- Reset release, default parameters: deassert rst_n, then read addresses 0..15 on A and B after ready rises -> ready=0 for edges 1..15 and 1 after edge 16; every read returns 0 with valid=1.
- Write then read: write 0xDEADBEEF to address 5, next cycle re_a_n=0 with dir_a=5 -> dat_a=0xDEADBEEF, valid_a=1 one cycle later.
- Bypass: same cycle we_n=0, dir_wr=7, di=0x12345678, re_b_n=0, dir_b=7, while address 7 holds 0 -> dat_b=0x12345678 on the next edge.
- Disabled port: re_a_n=1 -> dat_a=0xFFFFFFFF, valid_a=0; during CLEAR with re_a_n=0 -> still 0xFFFFFFFF, valid_a=0, and we_n=0 has no effect on the array.
- ZERO_REG=1: write 0xAAAA5555 to address 0, then read address 0 on both ports, including in the bypass cycle -> 0 on both ports. Address 1 write/read works normally.
- Clear request with a write in the same cycle (address 3, 0x55): fill entries with nonzero data, assert clr_n=0 together with that write -> ready falls next edge and returns after 16 edges; all entries read 0, address 3 included. Separately, assert rst_n=0 mid-clear -> clear restarts and takes the full 16 edges again.

Source files
------------

// File: rtl/reg_file_mp.sv
// Two-read/one-write register file with write-to-read bypass, optional zero register
// and a hardware clear sequencer that zeroes the array after reset or on request.
module reg_file_mp #(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          ADDR_W   = 4,
    parameter logic [DATA_W-1:0]    IDLE_VAL = {DATA_W{1'b1}},
    parameter bit                   ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] dir_a,
    input  logic [ADDR_W-1:0] dir_b,
    input  logic              re_a_n,
    input  logic              re_b_n,
    input  logic [ADDR_W-1:0] dir_wr,
    input  logic [DATA_W-1:0] di,
    input  logic              we_n,
    output logic [DATA_W-1:0] dat_a,
    output logic [DATA_W-1:0] dat_b,
    output logic              valid_a,
    output logic              valid_b,
    output logic              ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_next;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              last_c;
    logic              wr_en_c;
    logic [DATA_W-1:0] rd_a_c, rd_b_c;
    logic [DATA_W-1:0] dat_a_next, dat_b_next;
    logic              valid_a_next, valid_b_next, ready_next;

    // Read mux: hard-wired zero first, then bypass of the in-flight write, then the array.
    function automatic logic [DATA_W-1:0] rd_sel(input logic [ADDR_W-1:0] dir);
        if (ZERO_REG && (dir == '0))
            return '0;
        else if (!we_n && (dir_wr == dir))
            return di;
        else
            return mem[dir];
    endfunction

    assign last_c  = (clr_ptr == ADDR_W'(DEPTH - 1));
    assign wr_en_c = (state == RUN) && !we_n && clr_n && !(ZERO_REG && (dir_wr == '0));
    assign rd_a_c  = rd_sel(dir_a);
    assign rd_b_c  = rd_sel(dir_b);

    // State register and clear pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    // Next-state logic; the pointer wraps to 0 on the edge that clears the last entry.
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        case (state)
            CLEAR: begin
                clr_ptr_next = clr_ptr + ADDR_W'(1);
                if (last_c)
                    state_next = RUN;
            end
            RUN: begin
                if (!clr_n) begin
                    state_next   = CLEAR;
                    clr_ptr_next = '0;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // Output next values; reads issued in the clear-request cycle still complete.
    always_comb begin
        dat_a_next   = IDLE_VAL;
        dat_b_next   = IDLE_VAL;
        valid_a_next = 1'b0;
        valid_b_next = 1'b0;
        ready_next   = 1'b0;
        if (state == RUN) begin
            ready_next = clr_n;
            if (!re_a_n) begin
                dat_a_next   = rd_a_c;
                valid_a_next = 1'b1;
            end
            if (!re_b_n) begin
                dat_b_next   = rd_b_c;
                valid_b_next = 1'b1;
            end
        end else begin
            ready_next = last_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_a   <= IDLE_VAL;
            dat_b   <= IDLE_VAL;
            valid_a <= 1'b0;
            valid_b <= 1'b0;
            ready   <= 1'b0;
        end else begin
            dat_a   <= dat_a_next;
            dat_b   <= dat_b_next;
            valid_a <= valid_a_next;
            valid_b <= valid_b_next;
            ready   <= ready_next;
        end
    end

    // Array storage is deliberately outside reset; only the sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_ptr] <= '0;
        else if (wr_en_c)
            mem[dir_wr] <= di;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a default instance and a ZERO_REG=1 instance share stimulus.
module tb_reg_file_mp;

    localparam logic [31:0] IV = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n, clr_n, re_a_n, re_b_n, we_n;
    logic [3:0]  dir_a, dir_b, dir_wr;
    logic [31:0] di;
    logic [31:0] dat_a, dat_b, zdat_a, zdat_b;
    logic        valid_a, valid_b, ready, zvalid_a, zvalid_b, zready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .dir_a(dir_a), .dir_b(dir_b),
        .re_a_n(re_a_n), .re_b_n(re_b_n), .dir_wr(dir_wr), .di(di), .we_n(we_n),
        .dat_a(dat_a), .dat_b(dat_b), .valid_a(valid_a), .valid_b(valid_b), .ready(ready)
    );

    reg_file_mp #(.ZERO_REG(1'b1)) dutz (
        .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .dir_a(dir_a), .dir_b(dir_b),
        .re_a_n(re_a_n), .re_b_n(re_b_n), .dir_wr(dir_wr), .di(di), .we_n(we_n),
        .dat_a(zdat_a), .dat_b(zdat_b), .valid_a(zvalid_a), .valid_b(zvalid_b), .ready(zready)
    );

    typedef struct {
        logic        re_a_n;
        logic [3:0]  dir_a;
        logic        re_b_n;
        logic [3:0]  dir_b;
        logic        we_n;
        logic [3:0]  dir_wr;
        logic [31:0] di;
        logic [31:0] ea, eb, eaz, ebz;
        logic        va, vb;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr_n = 1'b1; re_a_n = 1'b1; re_b_n = 1'b1; we_n = 1'b1;
        dir_a = 4'd0; dir_b = 4'd0; dir_wr = 4'd0; di = 32'h0;
    endtask

    // Expects ready low for 15 edges and high after the 16th, outputs idle throughout.
    task automatic clear_check(input string tag);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk({tag, "_ready"}, 32'(ready), 32'(k == 16));
            chk({tag, "_zready"}, 32'(zready), 32'(k == 16));
            chk({tag, "_dat_a"}, dat_a, IV);
            chk({tag, "_valid_a"}, 32'(valid_a), 32'd0);
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            re_a_n = 1'b0; re_b_n = 1'b0;
            dir_a = 4'(i); dir_b = 4'(15 - i);
            step();
            chk({tag, "_dat_a"}, dat_a, 32'h0);
            chk({tag, "_dat_b"}, dat_b, 32'h0);
            chk({tag, "_valid_a"}, 32'(valid_a), 32'd1);
            chk({tag, "_valid_b"}, 32'(valid_b), 32'd1);
            chk({tag, "_zdat_a"}, zdat_a, 32'h0);
        end
        re_a_n = 1'b1; re_b_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd5, 32'hDEAD_BEEF, IV, IV, IV, IV, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4'd5, 1'b0, 4'd5, 1'b1, 4'd0, 32'h0,
                    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 4'd0, 1'b0, 4'd7, 1'b0, 4'd7, 32'h1234_5678,
                    IV, 32'h1234_5678, IV, 32'h1234_5678, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 4'd7, 1'b0, 4'd5, 1'b1, 4'd0, 32'h0,
                    32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'hAAAA_5555,
                    32'hAAAA_5555, 32'hAAAA_5555, 32'h0, 32'h0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 32'h0,
                    32'hAAAA_5555, 32'hAAAA_5555, 32'h0, 32'h0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 4'd1, 1'b0, 4'd0, 1'b0, 4'd1, 32'h1111_1111,
                    32'h1111_1111, 32'hAAAA_5555, 32'h1111_1111, 32'h0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 4'd1, 1'b0, 4'd1, 1'b1, 4'd0, 32'h0,
                    32'h1111_1111, 32'h1111_1111, 32'h1111_1111, 32'h1111_1111, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 32'h55,
                    32'h55, IV, 32'h55, IV, 1'b1, 1'b0};

        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_valid_a", 32'(valid_a), 32'd0);
        chk("rst_valid_b", 32'(valid_b), 32'd0);
        chk("rst_dat_a", dat_a, IV);
        chk("rst_dat_b", dat_b, IV);

        // Enables asserted during the clear must be ignored.
        #2 rst_n = 1'b1;
        re_a_n = 1'b0; dir_a = 4'd2; we_n = 1'b0; dir_wr = 4'd2; di = 32'h99;
        clear_check("boot");
        idle_inputs();
        read_all_zero("boot_rd");

        for (int v = 0; v < 9; v++) begin
            re_a_n = vecs[v].re_a_n; dir_a = vecs[v].dir_a;
            re_b_n = vecs[v].re_b_n; dir_b = vecs[v].dir_b;
            we_n = vecs[v].we_n; dir_wr = vecs[v].dir_wr; di = vecs[v].di;
            step();
            chk($sformatf("vec%0d_dat_a", v), dat_a, vecs[v].ea);
            chk($sformatf("vec%0d_dat_b", v), dat_b, vecs[v].eb);
            chk($sformatf("vec%0d_zdat_a", v), zdat_a, vecs[v].eaz);
            chk($sformatf("vec%0d_zdat_b", v), zdat_b, vecs[v].ebz);
            chk($sformatf("vec%0d_valid_a", v), 32'(valid_a), 32'(vecs[v].va));
            chk($sformatf("vec%0d_valid_b", v), 32'(valid_b), 32'(vecs[v].vb));
        end
        idle_inputs();

        // Asynchronous reset while in RUN with valid data on port A.
        #2 rst_n = 1'b0;
        #1;
        chk("mrun_rst_valid_a", 32'(valid_a), 32'd0);
        chk("mrun_rst_dat_a", dat_a, IV);
        chk("mrun_rst_ready", 32'(ready), 32'd0);
        #1 rst_n = 1'b1;
        clear_check("mrun");

        for (int i = 0; i < 16; i++) begin
            we_n = 1'b0; dir_wr = 4'(i); di = 32'h100 + 32'(i);
            step();
        end
        // Clear request together with a write to address 3 and a read of address 4.
        clr_n = 1'b0; we_n = 1'b0; dir_wr = 4'd3; di = 32'h55;
        re_a_n = 1'b0; dir_a = 4'd4;
        step();
        chk("clr_ready_fall", 32'(ready), 32'd0);
        chk("clr_read_dat_a", dat_a, 32'h104);
        chk("clr_read_valid_a", 32'(valid_a), 32'd1);
        idle_inputs();
        clear_check("clr");
        read_all_zero("clr_rd");

        // Reset five edges into a requested clear must restart the full sequence.
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("mclr_ready", 32'(ready), 32'd0);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        clear_check("mclr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
